// File: rtl/hwo_insn_stream.sv
// Loadable instruction memory with a one-shot / loop / counted-repeat playback
// controller and a valid/ready output; drives NOP whenever no word is valid.
module hwo_insn_stream #(
   parameter int            DW    = 32,
   parameter int            DEPTH = 89,
   parameter int            AW    = 7,
   parameter logic [DW-1:0] NOP   = 32'h1500_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   input  logic          stop,
   input  logic [1:0]    mode,
   input  logic [AW:0]   len,
   input  logic [7:0]    reps,
   output logic [DW-1:0] out_insn,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_idx,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);
   localparam logic [1:0]  M_LOOP  = 2'b01;
   localparam logic [1:0]  M_REP   = 2'b10;

   state_t        state_q;
   logic [AW-1:0] idx_q;
   logic [AW:0]   len_q;
   logic [7:0]    reps_q;
   logic [7:0]    pass_q;
   logic [1:0]    mode_q;
   logic          done_q;
   logic          err_q;
   logic [DW-1:0] mem_q [DEPTH];

   logic          run_w;
   logic          len_ok_w;
   logic          wr_ok_w;
   logic          wr_bad_w;
   logic          start_bad_w;
   logic          last_w;
   logic [7:0]    reps_d;

   assign run_w       = (state_q == RUN);
   assign len_ok_w    = (len != '0) && (len <= DEPTH_C);
   assign wr_ok_w     = wr_en && !run_w && ({1'b0, wr_addr} < DEPTH_C);
   assign wr_bad_w    = wr_en && !wr_ok_w;
   assign start_bad_w = start && !run_w && !len_ok_w;
   assign last_w      = ({1'b0, idx_q} == (len_q - ONE_C));
   // A repeat count of zero behaves as a single pass.
   assign reps_d      = (reps == 8'd0) ? 8'd1 : reps;

   // Memory has no reset so its contents survive a mid-run rst.
   always_ff @(posedge clk) begin
      if (wr_ok_w) mem_q[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         reps_q  <= '0;
         pass_q  <= '0;
         mode_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= wr_bad_w || start_bad_w;
         case (state_q)
            IDLE: begin
               if (start && len_ok_w) begin
                  state_q <= RUN;
                  idx_q   <= '0;
                  pass_q  <= 8'd1;
                  len_q   <= len;
                  reps_q  <= reps_d;
                  mode_q  <= mode;
               end
            end
            RUN: begin
               // stop wins over a simultaneous transfer; that word still counts as taken.
               if (stop) begin
                  state_q <= IDLE;
               end else if (out_ready) begin
                  if (!last_w) begin
                     idx_q <= idx_q + AW'(1);
                  end else if (mode_q == M_LOOP) begin
                     idx_q <= '0;
                  end else if (mode_q == M_REP && pass_q < reps_q) begin
                     idx_q  <= '0;
                     pass_q <= pass_q + 8'd1;
                  end else begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid = run_w;
   assign busy      = run_w;
   assign out_insn  = run_w ? mem_q[idx_q] : NOP;
   assign out_idx   = idx_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_hwo_insn_stream.sv
// Directed bench for hwo_insn_stream: per-cycle vector table plus a
// hand-written asynchronous reset-mid-run sequence.
module tb_hwo_insn_stream;

   localparam logic [31:0] NOPW = 32'h1500_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [6:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  mode = '0;
   logic [7:0]  len = '0;
   logic [7:0]  reps = '0;
   logic [31:0] out_insn;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [6:0]  out_idx;
   logic        busy;
   logic        done;
   logic        err;

   int tests = 0;
   int fails = 0;

   hwo_insn_stream dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .mode(mode), .len(len), .reps(reps),
      .out_insn(out_insn), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [6:0]  wa;
      logic [31:0] wd;
      logic        st;
      logic        sp;
      logic [1:0]  md;
      logic [7:0]  ln;
      logic [7:0]  rp;
      logic        rdy;
      logic        ev;
      logic [31:0] ei;
      logic [6:0]  eidx;
      logic        ed;
      logic        ee;
   } vec_t;

   vec_t tbl[$];

   function automatic void v(input logic we, input logic [6:0] wa, input logic [31:0] wd,
                             input logic st, input logic sp, input logic [1:0] md,
                             input logic [7:0] ln, input logic [7:0] rp, input logic rdy,
                             input logic ev, input logic [31:0] ei, input logic [6:0] eidx,
                             input logic ed, input logic ee);
      vec_t t;
      t.we = we; t.wa = wa; t.wd = wd; t.st = st; t.sp = sp; t.md = md;
      t.ln = ln; t.rp = rp; t.rdy = rdy; t.ev = ev; t.ei = ei; t.eidx = eidx;
      t.ed = ed; t.ee = ee;
      tbl.push_back(t);
   endfunction

   task automatic check(input string name, input logic ev, input logic [31:0] ei,
                        input logic [6:0] eidx, input logic ed, input logic ee);
      logic [40:0] act, exp;
      act = {out_valid, busy, out_insn, out_idx};
      exp = {ev, ev, ei, eidx};
      tests++;
      if (act !== exp || done !== ed || err !== ee) begin
         fails++;
         $display("FAIL %s: got valid=%b busy=%b insn=%h idx=%0d done=%b err=%b, want valid=%b busy=%b insn=%h idx=%0d done=%b err=%b",
                  name, out_valid, busy, out_insn, out_idx, done, err, ev, ev, ei, eidx, ed, ee);
      end
   endtask

   // Drive one cycle of inputs, clock it, then check the post-edge outputs.
   task automatic apply(input vec_t t, input string name);
      wr_en = t.we; wr_addr = t.wa; wr_data = t.wd; start = t.st; stop = t.sp;
      mode = t.md; len = t.ln; reps = t.rp; out_ready = t.rdy;
      @(posedge clk);
      #1;
      check(name, t.ev, t.ei, t.eidx, t.ed, t.ee);
   endtask

   initial begin
      vec_t t;
      // load
      v(1, 0, 32'h11, 0,0,0,0,0,0,  0, NOPW, 0, 0,0);
      v(1, 1, 32'h22, 0,0,0,0,0,0,  0, NOPW, 0, 0,0);
      v(1, 2, 32'h33, 0,0,0,0,0,0,  0, NOPW, 0, 0,0);
      v(1, 3, 32'h44, 0,0,0,0,0,0,  0, NOPW, 0, 0,0);
      // basic one-shot
      v(0,0,0, 1,0,0,4,0,1,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h33, 2, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h44, 3, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   3, 1,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   3, 0,0);
      // backpressure at idx 1
      v(0,0,0, 1,0,0,4,0,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,0,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,0,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,0,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h33, 2, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h44, 3, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   3, 1,0);
      // loop len 2, stop with the fifth transfer
      v(0,0,0, 1,0,1,2,0,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,1,0,0,0,1,  0, NOPW,   0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   0, 0,0);
      // repeat len 3 reps 2
      v(0,0,0, 1,0,2,3,2,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h33, 2, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h33, 2, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   2, 1,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   2, 0,0);
      // repeat with reps 0 -> single pass
      v(0,0,0, 1,0,2,3,0,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h33, 2, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   2, 1,0);
      // illegal commands in IDLE
      v(0,0,0, 1,0,0,0,0,0,  0, NOPW,   2, 0,1);
      v(0,0,0, 0,0,0,0,0,0,  0, NOPW,   2, 0,0);
      v(0,0,0, 1,0,0,90,0,0, 0, NOPW,   2, 0,1);
      v(1,89,32'hBAD, 0,0,0,0,0,0, 0, NOPW, 2, 0,1);
      v(0,0,0, 0,1,0,0,0,0,  0, NOPW,   2, 0,0);
      // write during RUN is dropped
      v(0,0,0, 1,0,0,4,0,0,  1, 32'h11, 0, 0,0);
      v(1,1,32'hDEAD, 0,0,0,0,0,0, 1, 32'h11, 0, 0,1);
      v(0,0,0, 0,0,0,0,0,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h33, 2, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h44, 3, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   3, 1,0);
      // reserved mode acts as one-shot; start in RUN ignored silently
      v(0,0,0, 1,0,3,2,0,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 1,0,0,1,0,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   1, 1,0);
      // start+stop together in IDLE: start proceeds
      v(0,0,0, 1,1,0,1,0,0,  1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   0, 1,0);
      // len = DEPTH is legal
      v(0,0,0, 1,0,0,89,0,0, 1, 32'h11, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  1, 32'h22, 1, 0,0);
      v(0,0,0, 0,1,0,0,0,0,  0, NOPW,   1, 0,0);
      // write at N visible to start at N+1
      v(1,0,32'h99, 0,0,0,0,0,0, 0, NOPW, 1, 0,0);
      v(0,0,0, 1,0,0,1,0,0,  1, 32'h99, 0, 0,0);
      v(0,0,0, 0,0,0,0,0,1,  0, NOPW,   0, 1,0);
      v(1,0,32'h11, 0,0,0,0,0,0, 0, NOPW, 0, 0,0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 0, NOPW, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("after_reset", 0, NOPW, 0, 0, 0);

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // asynchronous reset at idx 2 of a len-4 run
      t = '{we:0, wa:0, wd:0, st:1, sp:0, md:0, ln:4, rp:0, rdy:1,
            ev:1, ei:32'h11, eidx:0, ed:0, ee:0};
      apply(t, "rst_run0");
      t.st = 0; t.ei = 32'h22; t.eidx = 1;
      apply(t, "rst_run1");
      t.ei = 32'h33; t.eidx = 2;
      apply(t, "rst_run2");
      #3;
      rst = 1'b1;
      #1;
      check("rst_async", 0, NOPW, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      t.st = 1; t.ei = 32'h11; t.eidx = 0;
      apply(t, "restart0");
      t.st = 0; t.ei = 32'h22; t.eidx = 1;
      apply(t, "restart1");
      t.ei = 32'h33; t.eidx = 2;
      apply(t, "restart2");
      t.ei = 32'h44; t.eidx = 3;
      apply(t, "restart3");
      t.ev = 0; t.ei = NOPW; t.ed = 1;
      apply(t, "restart_done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
